signal_select: RTL and testbench



---
 rtl/signal_select_pkg.sv | 18 +
 rtl/signal_select_if.sv | 40 ++++
 rtl/signal_select_delay_stage.sv | 41 ++++
 rtl/signal_select.sv | 89 ++++++++
 tb/tb_signal_select.sv | 137 +++++++++++++
 5 files changed

// File: rtl/signal_select_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signal_select_pkg
// Description : Shared width/spacing constants and the signed sample type
//               for the signal_select tap delay line.
// Revision    : 1.0 - initial release
// ============================================================================
package signal_select_pkg;

    // Default sample width in bits (two's-complement).
    localparam int DATA_W      = 32;
    // Default cycles between adjacent taps (16-point radix-4 stride).
    localparam int TAP_SPACING = 4;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage : signal_select_pkg
`default_nettype wire

// File: rtl/signal_select_if.sv
`default_nettype none
// ============================================================================
// Module      : signal_select_if
// Description : Bundles the sample input and the four tap outputs of the
//               signal_select delay line. The master side drives samples,
//               the slave side presents the taps.
// Revision    : 1.0 - initial release
// ============================================================================
interface signal_select_if
    import signal_select_pkg::*;
#(
    parameter int DATA_W = signal_select_pkg::DATA_W
);

    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] delay_12;
    logic signed [DATA_W-1:0] delay_8;
    logic signed [DATA_W-1:0] delay_4;
    logic signed [DATA_W-1:0] delay_0;

    // Sample source: drives the stream, observes the taps.
    modport master (
        output in_data,
        input  delay_12,
        input  delay_8,
        input  delay_4,
        input  delay_0
    );

    // Delay line: consumes the stream, presents the taps.
    modport slave (
        input  in_data,
        output delay_12,
        output delay_8,
        output delay_4,
        output delay_0
    );

endinterface : signal_select_if
`default_nettype wire

// File: rtl/signal_select_delay_stage.sv
`default_nettype none
// ============================================================================
// Module      : delay_stage
// Description : DEPTH-deep shift register of DATA_W-bit words with a
//               synchronous active-high clear. dout is din delayed by
//               DEPTH rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_stage
    import signal_select_pkg::*;
#(
    parameter int DATA_W = signal_select_pkg::DATA_W,
    parameter int DEPTH  = signal_select_pkg::TAP_SPACING
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic signed [DATA_W-1:0] din,
    output      logic signed [DATA_W-1:0] dout
);

    logic signed [DATA_W-1:0] r_shift [DEPTH];

    // Shift one word in per edge; reset clears every word so stale history
    // never leaks out after a restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_shift[i] <= '0;
            end
        end else begin
            r_shift[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_shift[i] <= r_shift[i-1];
            end
        end
    end

    assign dout = r_shift[DEPTH-1];

endmodule : delay_stage
`default_nettype wire

// File: rtl/signal_select.sv
`default_nettype none
// ============================================================================
// Module      : signal_select
// Description : 3*TAP_SPACING-deep delay line presenting x[n-12], x[n-8],
//               x[n-4] and x[n] together as the stride-4 butterfly operand
//               set. Built from three chained delay_stage instances.
//               Option macro SIGNAL_SELECT_REG_OUT_EN: when defined, all four
//               outputs are registered (latencies 1/5/9/13) and the output
//               registers clear on reset; otherwise latencies are 0/4/8/12.
// Revision    : 1.0 - initial release
// ============================================================================
module signal_select
    import signal_select_pkg::*;
#(
    parameter int DATA_W      = signal_select_pkg::DATA_W,
    parameter int TAP_SPACING = signal_select_pkg::TAP_SPACING
) (
    input  wire logic signed [DATA_W-1:0] in_data,
    input  wire logic                     clk,
    input  wire logic                     reset,
    output      logic signed [DATA_W-1:0] delay_12,
    output      logic signed [DATA_W-1:0] delay_8,
    output      logic signed [DATA_W-1:0] delay_4,
    output      logic signed [DATA_W-1:0] delay_0
);

    // Tap values at depths TAP_SPACING, 2*TAP_SPACING, 3*TAP_SPACING.
    logic signed [DATA_W-1:0] w_tap [3];

    // Three stages in series form the single 3*TAP_SPACING-deep line.
    delay_stage #(
        .DATA_W (DATA_W),
        .DEPTH  (TAP_SPACING)
    ) u_stage_0 (
        .clk  (clk),
        .rst  (reset),
        .din  (in_data),
        .dout (w_tap[0])
    );

    generate
        for (genvar g = 1; g < 3; g++) begin : g_stage
            delay_stage #(
                .DATA_W (DATA_W),
                .DEPTH  (TAP_SPACING)
            ) u_stage (
                .clk  (clk),
                .rst  (reset),
                .din  (w_tap[g-1]),
                .dout (w_tap[g])
            );
        end
    endgenerate

`ifdef SIGNAL_SELECT_REG_OUT_EN
    logic signed [DATA_W-1:0] r_delay_12;
    logic signed [DATA_W-1:0] r_delay_8;
    logic signed [DATA_W-1:0] r_delay_4;
    logic signed [DATA_W-1:0] r_delay_0;

    // Output register: adds one cycle to every tap, cleared with the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_delay_12 <= '0;
            r_delay_8  <= '0;
            r_delay_4  <= '0;
            r_delay_0  <= '0;
        end else begin
            r_delay_12 <= w_tap[2];
            r_delay_8  <= w_tap[1];
            r_delay_4  <= w_tap[0];
            r_delay_0  <= in_data;
        end
    end

    assign delay_12 = r_delay_12;
    assign delay_8  = r_delay_8;
    assign delay_4  = r_delay_4;
    assign delay_0  = r_delay_0;
`else
    // Taps straight off the line; delay_0 is a pure wire, untouched by reset.
    assign delay_12 = w_tap[2];
    assign delay_8  = w_tap[1];
    assign delay_4  = w_tap[0];
    assign delay_0  = in_data;
`endif

endmodule : signal_select
`default_nettype wire

// File: tb/tb_signal_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_signal_select
// Description : Directed self-checking bench for signal_select. Expected
//               values are hand-computed; L shifts the check point by one
//               cycle when SIGNAL_SELECT_REG_OUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_select;

`ifdef SIGNAL_SELECT_REG_OUT_EN
    localparam int L = 1;
`else
    localparam int L = 0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_passed;

    signal_select_if #(.DATA_W(32)) sif ();

    signal_select #(
        .DATA_W      (32),
        .TAP_SPACING (4)
    ) dut (
        .in_data  (sif.in_data),
        .clk      (clk),
        .reset    (reset),
        .delay_12 (sif.delay_12),
        .delay_8  (sif.delay_8),
        .delay_4  (sif.delay_4),
        .delay_0  (sif.delay_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move 1 ns clear of it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_taps(input string tag, input logic [31:0] e12,
                            input logic [31:0] e8, input logic [31:0] e4);
        chk({tag, ".d12"}, sif.delay_12, e12);
        chk({tag, ".d8"},  sif.delay_8,  e8);
        chk({tag, ".d4"},  sif.delay_4,  e4);
    endtask

    logic [31:0] neg_seq [7];

    initial begin
        n_checks     = 0;
        n_passed     = 0;
        reset        = 1'b1;
        sif.in_data  = 32'sd0;
        neg_seq[0]   = 32'hFFFF_FFFF;
        neg_seq[1]   = 32'h8000_0000;
        for (int i = 2; i < 7; i++) neg_seq[i] = 32'h0;

        // Reset edge, then reset state with reset still high.
        tick();
        sif.in_data = 32'sd7;
        #2;
        chk_taps("rst", 32'h0, 32'h0, 32'h0);
`ifdef SIGNAL_SELECT_REG_OUT_EN
        chk("rst.d0", sif.delay_0, 32'h0);
`else
        chk("rst.d0", sif.delay_0, 32'h7);
`endif
        reset = 1'b0;

        // Counting stream 0..16.
        for (int v = 0; v <= 16; v++) begin
            sif.in_data = v;
            #2;
            if (v == 5 + L) chk_taps("fill5", 32'd0, 32'd0, 32'd1);
            if (v == 12 + L) begin
                chk_taps("s12", 32'd0, 32'd4, 32'd8);
                chk("s12.d0", sif.delay_0, 32'd12);
            end
            if (v == 15 + L) begin
                chk_taps("s15", 32'd3, 32'd7, 32'd11);
                chk("s15.d0", sif.delay_0, 32'd15);
            end
            tick();
        end

        // Mid-stream reset while in_data = 9.
        for (int v = 1; v <= 8; v++) begin
            sif.in_data = v;
            tick();
        end
        sif.in_data = 32'sd9;
        reset       = 1'b1;
        #2;
`ifndef SIGNAL_SELECT_REG_OUT_EN
        chk("mid.d0", sif.delay_0, 32'd9);
`endif
        tick();
        reset = 1'b0;
        for (int v = 10; v <= 20; v++) begin
            sif.in_data = v;
            #2;
            if (v == 10) chk_taps("mid", 32'd0, 32'd0, 32'd0);
            if (v == 14 + L) chk_taps("ref14", 32'd0, 32'd0, 32'd10);
            if (v == 18 + L) chk_taps("ref18", 32'd0, 32'd10, 32'd14);
            tick();
        end

        // Negative extremes pass bit-exact.
        for (int i = 0; i < 7; i++) begin
            sif.in_data = neg_seq[i];
            #2;
            if (i == 4 + L) chk("neg1.d4", sif.delay_4, 32'hFFFF_FFFF);
            if (i == 5 + L) chk("negmin.d4", sif.delay_4, 32'h8000_0000);
            tick();
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule : tb_signal_select
`default_nettype wire
